// File: rtl/key_entry_ctrl.sv
// Key-pulse sequencer: edits a BCD entry buffer and commits it over a valid/ready
// handshake, and forwards WASD presses as a separate single-entry direction command.
module key_entry_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                  clk_slow,
    input  logic                  rst,
    input  logic [9:0]            key_num,
    input  logic                  key_b,
    input  logic                  key_c,
    input  logic                  key_enter,
    input  logic                  key_w,
    input  logic                  key_a,
    input  logic                  key_s,
    input  logic                  key_d,
    input  logic                  num_ready,
    input  logic                  dir_ready,
    output logic [4*DIGITS-1:0]   entry_bcd,
    output logic [3:0]            entry_count,
    output logic                  num_valid,
    output logic [4*DIGITS-1:0]   num_bcd,
    output logic [3:0]            num_count,
    output logic                  dir_valid,
    output logic [1:0]            dir_code,
    output logic                  busy,
    output logic                  err
);

    // state | meaning
    // EDIT  | keys edit the entry buffer; Enter commits it
    // WAIT  | committed number pending; edit keys are rejected until num_ready
    localparam logic [0:0] EDIT = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    localparam int         W    = 4 * DIGITS;
    localparam logic [3:0] FULL = 4'(DIGITS);

    logic [0:0]   state, state_nx;
    logic [W-1:0] entry_nx, num_bcd_nx;
    logic [3:0]   count_nx, num_count_nx;
    logic         num_valid_nx;
    logic         edit_err;
    logic [3:0]   digit;
    logic [3:0]   num_hits;

    logic         dir_press, dir_open, dir_err;
    logic [1:0]   dir_sel;
    logic         dir_valid_nx;
    logic [1:0]   dir_code_nx;

    // Bit count tells single-digit presses apart from chorded (rejected) ones.
    always_comb begin
        digit    = 4'd0;
        num_hits = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (key_num[i]) begin
                digit    = 4'(i);
                num_hits = num_hits + 4'd1;
            end
        end
    end

    always_comb begin
        state_nx     = state;
        entry_nx     = entry_bcd;
        count_nx     = entry_count;
        num_bcd_nx   = num_bcd;
        num_count_nx = num_count;
        num_valid_nx = num_valid;
        edit_err     = 1'b0;
        if (state == EDIT) begin
            if (key_c) begin
                entry_nx = '0;
                count_nx = 4'd0;
            end else if (key_b) begin
                if (entry_count != 4'd0) begin
                    entry_nx = entry_bcd >> 4;
                    count_nx = entry_count - 4'd1;
                end else begin
                    edit_err = 1'b1;
                end
            end else if (key_enter) begin
                if (entry_count != 4'd0) begin
                    num_bcd_nx   = entry_bcd;
                    num_count_nx = entry_count;
                    num_valid_nx = 1'b1;
                    state_nx     = WAIT;
                end else begin
                    edit_err = 1'b1;
                end
            end else if (num_hits != 4'd0) begin
                if (num_hits == 4'd1 && entry_count < FULL) begin
                    entry_nx = (entry_bcd << 4) | W'(digit);
                    count_nx = entry_count + 4'd1;
                end else begin
                    edit_err = 1'b1;
                end
            end
        end else begin
            edit_err = (|key_num) | key_b | key_c | key_enter;
            if (num_valid && num_ready) begin
                num_valid_nx = 1'b0;
                entry_nx     = '0;
                count_nx     = 4'd0;
                state_nx     = EDIT;
            end
        end
    end

    // A new press may replace a command that is being consumed this same cycle.
    always_comb begin
        dir_press = key_w | key_a | key_s | key_d;
        dir_open  = ~dir_valid | dir_ready;
        dir_err   = dir_press & ~dir_open;
        if (key_w)      dir_sel = 2'd0;
        else if (key_a) dir_sel = 2'd1;
        else if (key_s) dir_sel = 2'd2;
        else            dir_sel = 2'd3;
        dir_valid_nx = dir_valid;
        dir_code_nx  = dir_code;
        if (dir_press && dir_open) begin
            dir_valid_nx = 1'b1;
            dir_code_nx  = dir_sel;
        end else if (dir_valid && dir_ready) begin
            dir_valid_nx = 1'b0;
        end
    end

    always_ff @(posedge clk_slow or negedge rst) begin
        if (!rst) begin
            state       <= EDIT;
            entry_bcd   <= '0;
            entry_count <= 4'd0;
            num_valid   <= 1'b0;
            num_bcd     <= '0;
            num_count   <= 4'd0;
            dir_valid   <= 1'b0;
            dir_code    <= 2'd0;
            err         <= 1'b0;
        end else begin
            state       <= state_nx;
            entry_bcd   <= entry_nx;
            entry_count <= count_nx;
            num_valid   <= num_valid_nx;
            num_bcd     <= num_bcd_nx;
            num_count   <= num_count_nx;
            dir_valid   <= dir_valid_nx;
            dir_code    <= dir_code_nx;
            err         <= edit_err | dir_err;
        end
    end

    assign busy = (state == WAIT);

endmodule

// File: doc/key_entry_ctrl.md
# key_entry_ctrl

Sequencing controller that sits directly behind the PS/2 key-pulse decoder. It turns the one-cycle key pulses into two handshaked command streams for the game/application logic:
- a multi-digit BCD number, edited with digits, backspace (B) and clear (C) and committed with Enter;
- a single-entry WASD direction command.

All rejected key presses are reported on one error pulse.

## Interface
Parameters:
- DIGITS, 4, maximum number of BCD digits held in the entry buffer (1..8)

Ports:
- clk_slow  in  1  system clock; all key pulses are synchronous, single-cycle pulses in this domain
- rst  in  1  reset, asynchronous, active-low
- key_num  in  10  one-hot digit pulses; bit i = digit i
- key_b  in  1  backspace pulse
- key_c  in  1  clear pulse
- key_enter  in  1  commit pulse
- key_w, key_a, key_s, key_d  in  1 each  direction pulses
- num_ready  in  1  consumer accepts the committed number
- dir_ready  in  1  consumer accepts the direction command
- entry_bcd  out  4*DIGITS  live edit buffer; digit 0 in bits [3:0] (least significant, most recently typed)
- entry_count  out  4  number of digits currently in the buffer (0..DIGITS)
- num_valid  out  1  committed number available
- num_bcd  out  4*DIGITS  committed number, same layout as entry_bcd
- num_count  out  4  digit count of the committed number
- dir_valid  out  1  direction command available
- dir_code  out  2  direction code: W=0, A=1, S=2, D=3
- busy  out  1  high in state WAIT
- err  out  1  one-cycle pulse on any rejected key event

## Operation
- State machine EDIT / WAIT. Reset enters EDIT.
- EDIT, one action per cycle, priority key_c > key_b > key_enter > key_num:
  - key_c: clear the buffer and set count to 0. Never an error, even when the buffer is already empty.
  - key_b:
    - count>0: shift the buffer right one nibble, zero-fill the top nibble, count-1.
    - count==0: err.
  - key_enter:
    - count>0: copy entry_bcd/entry_count into num_bcd/num_count, set num_valid, go to WAIT.
    - count==0: err.
  - key_num: the action depends on how many bits are set.
    - Exactly one bit set and count<DIGITS: shift the buffer left one nibble, insert the digit at [3:0], count+1.
    - More than one bit set: err, buffer unchanged.
    - count==DIGITS (full): err, buffer unchanged.
  - A lower-priority pulse arriving in the same cycle as a higher-priority one is dropped silently (no err).
- WAIT:
  - num_bcd, num_count and num_valid hold stable.
  - Any key_num, key_b, key_c or key_enter pulse produces err and has no other effect.
  - When num_valid && num_ready is sampled: clear num_valid, clear the buffer, count=0, go to EDIT.
- Direction path is independent of the state machine and active in both states:
  - Priority among simultaneous pulses: W > A > S > D. Lower-priority simultaneous pulses are dropped silently.
  - Accepting a press loads dir_code and sets dir_valid.
  - A press is accepted when dir_valid==0, or when dir_valid && dir_ready in the same cycle (back-to-back; the new command replaces the consumed one).
  - A press while dir_valid && !dir_ready is dropped with err.
  - dir_valid clears on dir_valid && dir_ready when no new press is accepted.
- err is the OR of all reject conditions in a cycle. It is a single pulse even if several rejects coincide.

## Timing
- All outputs are registered.
- Reset values: entry_bcd=0, entry_count=0, num_valid=0, num_bcd=0, num_count=0, dir_valid=0, dir_code=0, busy=0, err=0. Reset is asynchronous and takes effect mid-operation, discarding any pending number or direction.
- Latency is 1 cycle from a key pulse to the updated entry_bcd/entry_count, num_valid, dir_valid or err.
- num_valid rises 1 cycle after key_enter. busy rises in the same cycle.
- Handshake completes on the rising edge where valid&&ready is sampled. valid drops in the next cycle unless reloaded (direction path only).
- EDIT resumes the cycle after the number handshake completes. A key pulse in the handshake cycle itself is still treated as a WAIT event (err).
- Pulses are assumed to be 1 cycle wide. A pulse held for N cycles is processed as N events.

## Test plan
- Type 1,2,3,4 then Enter with num_ready=0 for 5 cycles, then 1 → num_bcd=16'h1234, num_count=4, num_valid held for 5 cycles, then cleared with entry_count=0.
- Type 7,8, backspace, 9 → entry_bcd=16'h0079, count=2. Backspace ×3 → third backspace gives an err pulse and count stays 0.
- Type 5 digits with DIGITS=4 → 5th digit gives err, entry_bcd=first four digits. key_num=10'b0000000011 → err, no change.
- Enter on an empty buffer → err, state remains EDIT. key_c and key_b pulsed together with count=3 → buffer cleared, no err.
- W, then S while dir_ready=0 → dir_code=0, S gives err. Then D with dir_ready=1 in the same cycle → dir_code=3, dir_valid stays 1.
- Enter with count=2, then rst low in WAIT → all outputs zero asynchronously. After release, state is EDIT and typing 6 gives entry_bcd=16'h0006.
